// File: rtl/wb_master_bridge_if.sv
// Bundles the core request/response channels and the Wishbone B4 master port
// driven by wb_master_bridge.
interface wb_master_bridge_if #(
   parameter int TAGSIZE = 1
);
   logic                req_valid_i;
   logic                req_ready_o;
   logic [31:0]         req_addr_i;
   logic [31:0]         req_wdata_i;
   logic                req_we_i;
   logic [3:0]          req_be_i;

   logic                rsp_valid_o;
   logic                rsp_ready_i;
   logic [31:0]         rsp_rdata_o;
   logic                rsp_err_o;

   logic [31:0]         wb_adr_o;
   logic [31:0]         wb_dat_o;
   logic [3:0]          wb_sel_o;
   logic                wb_we_o;
   logic                wb_cyc_o;
   logic                wb_stb_o;
   logic                wb_lock_o;
   logic [TAGSIZE-1:0]  wb_tga_o;
   logic [TAGSIZE-1:0]  wb_tgd_o;
   logic [TAGSIZE-1:0]  wb_tgc_o;
   logic                wb_gnt_i;
   logic [31:0]         wb_dat_i;
   logic                wb_ack_i;
   logic                wb_err_i;
   logic                wb_rty_i;

   modport master (
      input  req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_be_i,
      output req_ready_o,
      input  rsp_ready_i,
      output rsp_valid_o, rsp_rdata_o, rsp_err_o,
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      output wb_lock_o, wb_tga_o, wb_tgd_o, wb_tgc_o,
      input  wb_gnt_i, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
   );

   modport slave (
      output req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_be_i,
      input  req_ready_o,
      output rsp_ready_i,
      input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      input  wb_lock_o, wb_tga_o, wb_tgd_o, wb_tgc_o,
      output wb_gnt_i, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
   );
endinterface

// File: rtl/wb_master_bridge.sv
// Turns each core valid/ready request into one Wishbone classic cycle with
// arbitration, bounded retry and timeout, returning one response per request.
module wb_master_bridge #(
   parameter int TAGSIZE     = 1,
   parameter int MAX_RETRY   = 3,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   wb_master_bridge_if.master    bus
);

   typedef enum logic [2:0] {IDLE, ARB, XFER, RETRY, RESP} state_t;

   localparam logic [7:0]         RETRY_LIMIT = 8'(MAX_RETRY);
   localparam logic [15:0]        TIMER_LAST  = 16'(TIMEOUT_CYC - 1);
   localparam logic [TAGSIZE-1:0] TAG_ZERO    = '0;

   state_t       state;
   logic [7:0]   retry_cnt;
   logic [15:0]  timer;
   logic         cyc_q, stb_q, req_ready_q, rsp_valid_q, rsp_err_q, we_q;
   logic [31:0]  adr_q, dat_q, rsp_rdata_q;
   logic [3:0]   sel_q;

   // Every output is a register so nothing on the Wishbone side reaches an
   // output combinationally; async reset drops cyc/stb at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         retry_cnt   <= '0;
         timer       <= '0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         we_q        <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         sel_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid_i && req_ready_q) begin
                  adr_q       <= bus.req_addr_i;
                  dat_q       <= bus.req_wdata_i;
                  we_q        <= bus.req_we_i;
                  sel_q       <= bus.req_be_i;
                  retry_cnt   <= '0;
                  req_ready_q <= 1'b0;
                  cyc_q       <= 1'b1;
                  state       <= ARB;
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            ARB: begin
               if (bus.wb_gnt_i) begin
                  stb_q <= 1'b1;
                  timer <= '0;
                  state <= XFER;
               end
            end
            XFER: begin
               timer <= timer + 16'd1;
               if (bus.wb_ack_i) begin
                  rsp_rdata_q <= we_q ? 32'd0 : bus.wb_dat_i;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  state       <= RESP;
               end else if (bus.wb_err_i ||
                            (bus.wb_rty_i && retry_cnt == RETRY_LIMIT) ||
                            (!bus.wb_rty_i && TIMEOUT_CYC != 0 && timer == TIMER_LAST)) begin
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  state       <= RESP;
               end else if (bus.wb_rty_i) begin
                  retry_cnt <= retry_cnt + 8'd1;
                  cyc_q     <= 1'b0;
                  stb_q     <= 1'b0;
                  state     <= RETRY;
               end
            end
            RETRY: begin
               cyc_q <= 1'b1;
               state <= ARB;
            end
            RESP: begin
               if (bus.rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               cyc_q       <= 1'b0;
               stb_q       <= 1'b0;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready_o = req_ready_q;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_rdata_o = rsp_rdata_q;
   assign bus.rsp_err_o   = rsp_err_q;
   assign bus.wb_adr_o    = adr_q;
   assign bus.wb_dat_o    = dat_q;
   assign bus.wb_sel_o    = sel_q;
   assign bus.wb_we_o     = we_q;
   assign bus.wb_cyc_o    = cyc_q;
   assign bus.wb_stb_o    = stb_q;
   assign bus.wb_lock_o   = 1'b0;
   assign bus.wb_tga_o    = TAG_ZERO;
   assign bus.wb_tgd_o    = TAG_ZERO;
   assign bus.wb_tgc_o    = TAG_ZERO;

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Converts a core-side valid/ready memory request stream into single Wishbone B4 classic master cycles, one per request.
- Sits directly upstream of the team's Wishbone interconnect and drives one master port of it, including the cyc/gnt arbitration handshake.
- Handles slave ack/err/rty, a bounded retry count and a transfer timeout.
- Returns one response per request on a valid/ready response channel.

Parameters:
TAGSIZE, 1, width of tga/tgd/tgc tag signals (driven constant 0)
MAX_RETRY, 3, number of rty responses tolerated per request before reporting error (0..255)
TIMEOUT_CYC, 256, max cycles in XFER before forced error; 0 disables timeout (0..65535)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
req_valid_i  in  1  core request valid
req_ready_o  out  1  bridge accepts request
req_addr_i  in  32  byte address
req_wdata_i  in  32  write data
req_we_i  in  1  1=write, 0=read
req_be_i  in  4  byte enables
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  core accepts response
rsp_rdata_o  out  32  read data (0 on write/error)
rsp_err_o  out  1  transfer failed (err, retries exhausted, timeout)
wb_adr_o  out  32  Wishbone address
wb_dat_o  out  32  Wishbone write data
wb_sel_o  out  4  Wishbone select
wb_we_o  out  1  Wishbone write enable
wb_cyc_o  out  1  cycle in progress / bus request
wb_stb_o  out  1  strobe
wb_lock_o  out  1  interconnect lock, constant 0
wb_tga_o, wb_tgd_o, wb_tgc_o  out  TAGSIZE each  constant 0
wb_gnt_i  in  1  grant from interconnect
wb_dat_i  in  32  read data
wb_ack_i  in  1  slave ack
wb_err_i  in  1  slave error
wb_rty_i  in  1  slave retry

Behaviour:
- Reset rst_i, asynchronous, active-high; clock clk_i. On reset: state=IDLE, retry_cnt=0, timer=0, all request/response registers 0, every output 0 (req_ready_o=1 once reset deasserts). Reset mid-cycle drops wb_cyc_o/wb_stb_o immediately; the pending request and response are discarded.
- All outputs derive from registered state and registers; there are no combinational paths from Wishbone inputs to any output.
- States: IDLE, ARB, XFER, RETRY, RESP.
- wb_cyc_o=1 in ARB and XFER. wb_stb_o=1 in XFER only. req_ready_o=1 in IDLE only. rsp_valid_o=1 in RESP only.
- IDLE:
  - On req_valid_i: latch addr/wdata/we/be into wb_adr_o/wb_dat_o/wb_we_o/wb_sel_o; retry_cnt=0; go to ARB.
  - Address/data outputs hold their value until the next accept.
- ARB: wait for wb_gnt_i=1, then go to XFER. There is no timeout while waiting for grant.
- XFER (timer increments each cycle, cleared on entry). Per-cycle priority is ack > err > rty > timeout:
  - ack: capture rdata (forced to 0 if we=1); err=0; go to RESP.
  - err: rdata=0, err=1; go to RESP.
  - rty with retry_cnt<MAX_RETRY: retry_cnt+1; go to RETRY.
  - rty with retry_cnt==MAX_RETRY: err=1; go to RESP.
  - TIMEOUT_CYC!=0 and timer==TIMEOUT_CYC-1 with no response: err=1; go to RESP. Total stb duration is exactly TIMEOUT_CYC cycles.
- RETRY: cyc=stb=0 for exactly one cycle, releasing the bus for re-arbitration; then go to ARB.
- RESP: hold rsp_* stable until rsp_ready_i=1; go to IDLE in the same cycle as the handshake. A new request is accepted no earlier than the following cycle.
- Minimum latency with immediate gnt and ack: accept at cycle 0; cyc at 1; stb at 2; ack seen at 2; rsp_valid at 3.
- Responses are returned strictly in order. Exactly one response is produced per accepted request.

Test Plan:
- Read, gnt tied 1, ack on first stb cycle with dat_i=0xDEADBEEF, addr 0x1000 -> cyc 1 at cycles 1–2, stb at cycle 2; rsp_valid at cycle 3 with rdata=0xDEADBEEF, err=0.
- Write addr 0x2004, wdata 0x12345678, be=0b0011 -> wb_adr/dat/sel/we = 0x2004/0x12345678/0x3/1 during stb; rsp rdata=0, err=0.
- gnt held 0 for 10 cycles, then 1 -> cyc high throughout, stb begins the cycle after gnt; no timeout fires.
- MAX_RETRY=3, slave answers rty four times -> three RETRY gaps (cyc=0 for one cycle each), fourth rty gives rsp err=1; total stb assertions = 4.
- TIMEOUT_CYC=8, no ack -> stb high exactly 8 cycles, then rsp err=1; simultaneous ack+rty -> ack wins, err=0.
- rsp_ready_i held 0 for 5 cycles -> rsp stable, req_ready_o=0; assert rst_i mid-XFER -> cyc/stb drop asynchronously, back to IDLE with no response.
